// File: rtl/if_fetch.sv
// Instruction fetch: PC register, instruction SRAM read port, stall-safe instruction hold and redirect buffer.
// Optional misaligned-fetch check (if_excp_adel) is built when IF_ALIGN_CHECK_EN is defined.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC,
  parameter int          STALL_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic [32:0]        br_bus,
  output logic [32:0]        if_to_id_bus,
  output logic [31:0]        if_inst,
  output logic               if_excp_adel,
  output logic               inst_sram_en,
  output logic [3:0]         inst_sram_wen,
  output logic [31:0]        inst_sram_addr,
  output logic [31:0]        inst_sram_wdata,
  input  logic [31:0]        inst_sram_rdata
);

  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;
  logic        redir_vld_q, redir_vld_d;
  logic [31:0] redir_addr_q, redir_addr_d;
  logic        hold_vld_q, hold_vld_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] next_pc;
  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] live_inst;
  logic        unused_stall;

  assign {br_e, br_addr} = br_bus;
  // Only the two lowest stall bits concern this stage.
  assign unused_stall = ^stall;

  always_comb begin
    next_pc = pc_q + 32'd4;
    if (br_e) begin
      next_pc = br_addr;
    end else if (redir_vld_q) begin
      next_pc = redir_addr_q;
    end
  end

  always_comb begin
    pc_d         = pc_q;
    ce_d         = ce_q;
    redir_vld_d  = redir_vld_q;
    redir_addr_d = redir_addr_q;
    hold_vld_d   = hold_vld_q;
    hold_inst_d  = hold_inst_q;

    if (!stall[0]) begin
      pc_d        = next_pc;
      ce_d        = 1'b1;
      redir_vld_d = 1'b0;
    end else if (br_e) begin
      redir_vld_d  = 1'b1;
      redir_addr_d = br_addr;
    end

    // Capture the word once on stall entry so decode keeps the one matching its PC.
    if (stall[1]) begin
      if (!hold_vld_q) begin
        hold_vld_d  = 1'b1;
        hold_inst_d = inst_sram_rdata;
      end
    end else begin
      hold_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      ce_q         <= 1'b0;
      redir_vld_q  <= 1'b0;
      redir_addr_q <= 32'b0;
      hold_vld_q   <= 1'b0;
      hold_inst_q  <= 32'b0;
    end else begin
      pc_q         <= pc_d;
      ce_q         <= ce_d;
      redir_vld_q  <= redir_vld_d;
      redir_addr_q <= redir_addr_d;
      hold_vld_q   <= hold_vld_d;
      hold_inst_q  <= hold_inst_d;
    end
  end

  assign live_inst = hold_vld_q ? hold_inst_q : inst_sram_rdata;

`ifdef IF_ALIGN_CHECK_EN
  assign if_excp_adel = ce_q & (pc_q[1:0] != 2'b00);
  assign if_inst      = if_excp_adel ? 32'b0 : live_inst;
`else
  assign if_excp_adel = 1'b0;
  assign if_inst      = live_inst;
`endif

  assign if_to_id_bus    = {ce_q, pc_q};
  assign inst_sram_en    = ce_q & ~if_excp_adel;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_addr  = pc_q;
  assign inst_sram_wdata = 32'b0;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a stimulus table pushes expected outputs, a negedge monitor pops and compares.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic [31:0] if_inst;
  logic        if_excp_adel;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  if_fetch #(.RESET_PC(32'hBFBF_FFFC), .STALL_W(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .br_bus         (br_bus),
    .if_to_id_bus   (if_to_id_bus),
    .if_inst        (if_inst),
    .if_excp_adel   (if_excp_adel),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_wen  (inst_sram_wen),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  typedef struct {
    logic [1:0]  st;
    logic        be;
    logic [31:0] ba;
    logic [31:0] rd;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } row_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
    logic        en;
  } exp_t;

  row_t rows[$];
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_on = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic add(input logic [1:0] st, input logic be, input logic [31:0] ba,
                     input logic [31:0] rd, input logic [31:0] pc, input logic [31:0] inst,
                     input logic mis);
    row_t r;
    r.st = st; r.be = be; r.ba = ba; r.rd = rd; r.pc = pc; r.inst = inst; r.mis = mis;
    rows.push_back(r);
  endtask

  always @(negedge clk) begin
    if (mon_on && rst && if_to_id_bus[32]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: pc=%h with no expectation queued", if_to_id_bus[31:0]);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pc", if_to_id_bus[31:0], e.pc);
        chk("sram_addr", inst_sram_addr, e.pc);
        chk("if_inst", if_inst, e.inst);
        chk("adel", {31'b0, if_excp_adel}, {31'b0, e.adel});
        chk("sram_en", {31'b0, inst_sram_en}, {31'b0, e.en});
        chk("sram_wen", {28'b0, inst_sram_wen}, 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst = 1'b0;
    stall = 6'b0;
    br_bus = 33'b0;
    inst_sram_rdata = 32'hDEAD_BEEF;

    //  st     be    br_addr        rdata          pc             inst         mis
    add(2'b00, 1'b0, 32'h0,         32'h0000_1000, 32'hBFC0_0000, 32'h0000_1000, 1'b0);
    add(2'b00, 1'b0, 32'h0,         32'h0000_1001, 32'hBFC0_0004, 32'h0000_1001, 1'b0);
    add(2'b00, 1'b0, 32'h0,         32'h0000_1002, 32'hBFC0_0008, 32'h0000_1002, 1'b0);
    add(2'b00, 1'b0, 32'h0,         32'h0000_1003, 32'hBFC0_000C, 32'h0000_1003, 1'b0);
    add(2'b00, 1'b1, 32'hBFC0_0100, 32'h0000_1004, 32'hBFC0_0010, 32'h0000_1004, 1'b0);
    add(2'b00, 1'b0, 32'h0,         32'h0000_1005, 32'hBFC0_0100, 32'h0000_1005, 1'b0);
    add(2'b00, 1'b0, 32'h0,         32'h0000_1006, 32'hBFC0_0104, 32'h0000_1006, 1'b0);
    add(2'b01, 1'b0, 32'h0,         32'h0000_1007, 32'hBFC0_0108, 32'h0000_1007, 1'b0);
    add(2'b01, 1'b1, 32'h8000_0040, 32'h0000_1008, 32'hBFC0_0108, 32'h0000_1008, 1'b0);
    add(2'b01, 1'b0, 32'h0,         32'h0000_1009, 32'hBFC0_0108, 32'h0000_1009, 1'b0);
    add(2'b00, 1'b0, 32'h0,         32'h0000_100A, 32'hBFC0_0108, 32'h0000_100A, 1'b0);
    add(2'b00, 1'b0, 32'h0,         32'h0000_100B, 32'h8000_0040, 32'h0000_100B, 1'b0);
    add(2'b11, 1'b0, 32'h0,         32'hAAAA_0001, 32'h8000_0044, 32'hAAAA_0001, 1'b0);
    add(2'b11, 1'b0, 32'h0,         32'hBBBB_0002, 32'h8000_0044, 32'hAAAA_0001, 1'b0);
    add(2'b00, 1'b0, 32'h0,         32'hCCCC_0003, 32'h8000_0044, 32'hAAAA_0001, 1'b0);
    add(2'b00, 1'b0, 32'h0,         32'hDDDD_0004, 32'h8000_0048, 32'hDDDD_0004, 1'b0);
    add(2'b01, 1'b1, 32'h8000_0040, 32'h0000_1010, 32'h8000_004C, 32'h0000_1010, 1'b0);
    add(2'b00, 1'b1, 32'h8000_0080, 32'h0000_1011, 32'h8000_004C, 32'h0000_1011, 1'b0);
    add(2'b01, 1'b0, 32'h0,         32'h0000_1012, 32'h8000_0080, 32'h0000_1012, 1'b0);
    add(2'b00, 1'b0, 32'h0,         32'h0000_1013, 32'h8000_0080, 32'h0000_1013, 1'b0);
    add(2'b00, 1'b1, 32'hBFC0_0102, 32'h0000_1014, 32'h8000_0084, 32'h0000_1014, 1'b0);
    add(2'b00, 1'b0, 32'h0,         32'h0000_1015, 32'hBFC0_0102, 32'h0000_1015, 1'b1);
    add(2'b00, 1'b0, 32'h0,         32'h0000_1016, 32'hBFC0_0106, 32'h0000_1016, 1'b1);
    add(2'b01, 1'b1, 32'h1234_5678, 32'h0000_1017, 32'hBFC0_010A, 32'h0000_1017, 1'b1);

    #12;
    chk("reset_ce", {31'b0, if_to_id_bus[32]}, 32'h0);
    chk("reset_pc", if_to_id_bus[31:0], 32'hBFBF_FFFC);
    chk("reset_sram_en", {31'b0, inst_sram_en}, 32'h0);
    chk("reset_adel", {31'b0, if_excp_adel}, 32'h0);
    chk("reset_if_inst", if_inst, 32'hDEAD_BEEF);
    chk("reset_wen", {28'b0, inst_sram_wen}, 32'h0);
    chk("reset_wdata", inst_sram_wdata, 32'h0);

    #10;
    rst = 1'b1;
    mon_on = 1'b1;

    foreach (rows[i]) begin
      @(posedge clk);
      #1;
      stall = {4'b0, rows[i].st};
      br_bus = {rows[i].be, rows[i].ba};
      inst_sram_rdata = rows[i].rd;
      e.pc = rows[i].pc;
`ifdef IF_ALIGN_CHECK_EN
      e.adel = rows[i].mis;
      e.en   = ~rows[i].mis;
      e.inst = rows[i].mis ? 32'h0 : rows[i].inst;
`else
      e.adel = 1'b0;
      e.en   = 1'b1;
      e.inst = rows[i].inst;
`endif
      exp_q.push_back(e);
    end

    // Reset lands while the PC is frozen with a redirect buffered.
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midreset_ce", {31'b0, if_to_id_bus[32]}, 32'h0);
    chk("midreset_pc", if_to_id_bus[31:0], 32'hBFBF_FFFC);
    chk("midreset_sram_en", {31'b0, inst_sram_en}, 32'h0);
    chk("midreset_if_inst", if_inst, 32'h0000_1017);
    stall = 6'b0;
    br_bus = 33'b0;
    inst_sram_rdata = 32'h0000_2000;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    e.pc = 32'hBFC0_0000;
    e.inst = 32'h0000_2000;
    e.adel = 1'b0;
    e.en = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
    mon_on = 1'b0;
    chk("queue_drained", exp_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC and drives the instruction SRAM read port. Produces `if_to_id_bus` for the decode stage and consumes the decode stage's branch redirect on `br_bus`. Owns the stall-safe instruction hold, so decode always sees the word belonging to its registered PC, and it buffers redirects that arrive while the PC is frozen.

## Interface
Parameters:
- `RESET_PC`, 32'hBFBF_FFFC: PC register value at reset. The first fetched address is `RESET_PC+4` = 32'hBFC0_0000.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `stall`  in  `StallBus`  stall vector; `Stop`=1. Bit 0 freezes the PC, bit 1 freezes decode. Monotonic: `stall[k]` implies `stall[j]` for all j<k.
- `br_bus`  in  `BR_WD` (33)  {br_e, br_addr[31:0]} from decode.
- `if_to_id_bus`  out  `IF_TO_ID_WD` (33)  {ce, pc[31:0]}.
- `if_inst`  out  32  instruction word for decode.
- `if_excp_adel`  out  1  misaligned-fetch flag for the current `pc`.
- `inst_sram_en`  out  1  read enable.
- `inst_sram_wen`  out  4  always 4'b0000.
- `inst_sram_addr`  out  32  fetch address.
- `inst_sram_wdata`  out  32  always 32'b0.
- `inst_sram_rdata`  in  32  read data. Synchronous SRAM: data for the address sampled at edge N is valid after edge N.

## Operation
- Registers: `pc_reg`, `ce_reg`, `redir_valid`/`redir_addr` (pending-redirect buffer), `hold_valid`/`hold_inst` (instruction hold).
- Combinational: `ce` = `ce_reg`; `pc` = `pc_reg`; `inst_sram_en` = `ce_reg` & ~`if_excp_adel`; `inst_sram_addr` = `pc_reg`.
- Next PC, highest priority first:
  1. live `br_e` → `br_addr`
  2. `redir_valid` → `redir_addr`
  3. otherwise `pc_reg+4`. Wraps modulo 2^32; no carry out.
- `stall[0]`=NoStop: `pc_reg`←next PC, `ce_reg`←1, `redir_valid`←0.
- `stall[0]`=Stop: `pc_reg` and `ce_reg` hold.
  - If `br_e`=1, then `redir_valid`←1 and `redir_addr`←`br_addr`. A later `br_e` during the same stall overwrites the buffer.
  - Otherwise the buffer holds.
- Instruction hold:
  - On the first edge where `stall[1]`=Stop and `hold_valid`=0: `hold_inst`←`inst_sram_rdata`, `hold_valid`←1.
  - While `stall[1]`=Stop and `hold_valid`=1: hold.
  - When `stall[1]`=NoStop: `hold_valid`←0.
- `if_inst` = `hold_valid` ? `hold_inst` : `inst_sram_rdata`.
- States:
  - RESET: `ce_reg`=0.
  - RUN: `stall[0]`=0.
  - HOLD: `stall[0]`=1.
  - HOLD_REDIR: HOLD with `redir_valid`=1.
- Transitions:
  - RESET→RUN on the first non-stalled edge.
  - RUN↔HOLD follows `stall[0]`.
  - HOLD→HOLD_REDIR on `br_e`.
  - HOLD_REDIR→RUN on release; the buffer is consumed.

## Timing
- Reset values (asynchronous):
  - `pc_reg`=`RESET_PC`, `ce_reg`=0, `redir_valid`=0, `redir_addr`=0, `hold_valid`=0, `hold_inst`=0.
  - Resulting outputs: `ce`=0, `inst_sram_en`=0, `if_excp_adel`=0, `if_inst`=`inst_sram_rdata`.
- First edge after reset release with `stall[0]`=0: `pc`=32'hBFC0_0000 and `ce`=1.
- One-cycle fetch latency. The word for `pc` is on `inst_sram_rdata` the cycle after `pc` is presented. This is the same cycle in which decode holds that `pc` in its input register.
- A redirect takes effect on the next edge. The fetch following the delay slot uses the target, with no bubble.
- Simultaneous release and live `br_e`: the live branch wins, and the buffer is cleared in the same edge.
- Reset asserted mid-stall or mid-redirect: all state clears immediately, with no waiting for a clock.

## Configuration
- `IF_ALIGN_CHECK_EN` defined:
  - `if_excp_adel` = `ce_reg` & (`pc_reg[1:0]`≠0).
  - While it is set, `inst_sram_en`=0 and `if_inst` is forced to 32'b0 (a nop).
  - The PC still advances normally.
- Not defined: `if_excp_adel` is tied to 0, no check logic exists, and `inst_sram_en`=`ce_reg`.

## Test plan
- Reset then release, no stalls → `pc` sequence BFC0_0000, BFC0_0004, BFC0_0008; `ce`=1 from the first edge; `inst_sram_wen`=0 throughout.
- At `pc`=BFC0_0010, pulse `br_e`=1 with `br_addr`=BFC0_0100 for one cycle → next `pc`=BFC0_0100, then BFC0_0104.
- Hold `stall[0]`=1 for 3 cycles with `br_e` pulsed at `br_addr`=8000_0040 in cycle 2 → `pc` frozen, then 8000_0040 on release.
- `stall[1:0]`=11 for 2 cycles, with SRAM returning A then B → `if_inst` stays A for both cycles; after release `if_inst` follows SRAM again.
- Release coinciding with live `br_e` to 8000_0080 while the buffer holds 8000_0040 → `pc`=8000_0080 and `redir_valid`=0.
- With `IF_ALIGN_CHECK_EN`, branch to BFC0_0102 → `if_excp_adel`=1, `inst_sram_en`=0, `if_inst`=0, next `pc`=BFC0_0106.
